// File: rtl/mii_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mii_rx_pkg
// Description : Shared definitions for the MII/RMII receive stream bridge:
//               FSM state encodings, SFD value, CRC-32 constants, the FIFO
//               entry width and the CRC helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mii_rx_pkg;

    // Receive FSM state encoding
    localparam int                   C_STATE_W   = 3;
    localparam logic [C_STATE_W-1:0] C_ST_IDLE     = 3'd0;
    localparam logic [C_STATE_W-1:0] C_ST_PREAMBLE = 3'd1;
    localparam logic [C_STATE_W-1:0] C_ST_DATA     = 3'd2;
    localparam logic [C_STATE_W-1:0] C_ST_DROP     = 3'd3;
    localparam logic [C_STATE_W-1:0] C_ST_TAIL     = 3'd4;

    // Start-of-frame delimiter as it appears in the LSB-first shift register
    localparam logic [7:0]  C_SFD         = 8'hD5;

    // IEEE 802.3 CRC-32, reflected polynomial and the good-frame residue
    // (residue expressed in the non-reflected bit order)
    localparam logic [31:0] C_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] C_CRC_RESIDUE = 32'hC704DD7B;

    // FIFO entry: {err, last, data[7:0]}
    localparam int          C_ENTRY_W     = 10;

    // One byte of reflected CRC-32, data consumed LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ C_CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

    // Reverse bit order so the reflected register can be compared with the
    // residue constant
    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mii_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mii_rx_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               always presented on o_rdata while o_empty is low. A push into
//               a full FIFO is accepted only when a pop happens in the same
//               cycle.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (empties the FIFO)
//               i_push   - write request, i_wdata - write entry
//               i_pop    - read request (ignored when empty)
//               o_rdata  - head entry, o_full / o_empty - status
// Revision    : 1.0 - initial release
// ============================================================================
module mii_rx_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                       (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[C_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[C_AW-1:0]] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mii_rx_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mii_rx_stream_bridge
// Description : MII (4-bit) / RMII (2-bit) receive front end. Strips the
//               preamble and SFD, assembles LSB-first bytes, applies length
//               and error checks, buffers frames in a FWFT FIFO and presents
//               them as a ready/valid byte stream with last/err tags.
// Ports       : clk_clk          - block clock
//               reset_reset_n    - synchronous active-low reset
//               rx_sym_en        - symbol strobe; rx_d/rx_dv/rx_err valid
//               rx_d, rx_dv, rx_err - receive symbol, data valid, PHY error
//               out_data/out_valid/out_ready/out_last/out_err - byte stream
//               frames_ok, frames_err - saturating frame counters
//               overflow_sticky  - a frame was truncated by a full FIFO
// Options     : MII_RX_FCS_CHECK_EN - build the CRC-32 FCS checker
// Revision    : 1.0 - initial release
// ============================================================================
module mii_rx_stream_bridge
    import mii_rx_pkg::*;
#(
    parameter int SYM_W      = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518,
    parameter int CNT_W      = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             rx_sym_en,
    input  logic [SYM_W-1:0] rx_d,
    input  logic             rx_dv,
    input  logic             rx_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_err,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic             overflow_sticky
);

    localparam int                C_SYMS    = 8 / SYM_W;
    localparam int                C_PH_W    = (C_SYMS > 1) ? $clog2(C_SYMS) : 1;
    localparam int                C_LEN_W   = $clog2(MAX_FRAME + 2);
    localparam logic [C_PH_W-1:0] C_PH_LAST = C_PH_W'(C_SYMS - 1);
    localparam logic [C_LEN_W-1:0] C_LEN_MAX = C_LEN_W'(MAX_FRAME);
    localparam logic [C_LEN_W-1:0] C_LEN_MIN = C_LEN_W'(MIN_FRAME);

    // Registered state
    logic [C_STATE_W-1:0] r_state;
    logic [7:0]           r_shift;
    logic [C_PH_W-1:0]    r_phase;
    logic [C_LEN_W-1:0]   r_len;
    logic [7:0]           r_stage_data;
    logic                 r_stage_valid;
    logic                 r_err_flag;
    logic                 r_tail_stage;     // tail carries the staged byte (MAX cut)
    logic                 r_overflow;
    logic [CNT_W-1:0]     r_frames_ok;
    logic [CNT_W-1:0]     r_frames_err;

    // Combinational decode
    logic                 w_rst;
    logic [7:0]           w_shift_next;
    logic                 w_byte_done;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_fcs_bad;
    logic                 w_end_err;
    logic                 w_push;
    logic [C_ENTRY_W-1:0] w_push_entry;
    logic                 w_sfd_hit;
    logic                 w_byte_store;
    logic                 w_cut;
    logic                 w_overflow;
    logic                 w_frame_end;
    logic                 w_tail_write;

    // FIFO interface
    logic [C_ENTRY_W-1:0] w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_rst        = !reset_reset_n;
    assign w_shift_next = {rx_d, r_shift[7:SYM_W]};
    assign w_byte_done  = (r_phase == C_PH_LAST);
    assign w_pop        = !w_fifo_empty && out_ready;
    // A pop in the same cycle frees the slot a push needs
    assign w_room       = !w_fifo_full || w_pop;
    assign w_end_err    = r_err_flag || (r_phase != '0) || (r_len < C_LEN_MIN) || w_fcs_bad;

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] r_crc;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_crc <= '1;
        end else if (w_sfd_hit) begin
            r_crc <= '1;
        end else if (w_byte_store) begin
            r_crc <= crc32_byte(r_crc, w_shift_next);
        end
    end

    // Staged byte is already folded in, so the residue covers data + FCS
    assign w_fcs_bad = (bit_reverse32(r_crc) != C_CRC_RESIDUE);
`else
    assign w_fcs_bad = 1'b0;
`endif

    // Push decisions and events shared by the FSM and the CRC
    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '0;
        w_sfd_hit    = 1'b0;
        w_byte_store = 1'b0;
        w_cut        = 1'b0;
        w_overflow   = 1'b0;
        w_frame_end  = 1'b0;
        w_tail_write = 1'b0;
        case (r_state)
            C_ST_PREAMBLE: begin
                w_sfd_hit = rx_sym_en && rx_dv && (w_shift_next == C_SFD);
            end
            C_ST_DATA: begin
                if (rx_sym_en) begin
                    if (rx_dv) begin
                        if (w_byte_done) begin
                            if (r_len == C_LEN_MAX) begin
                                // This byte would exceed MAX_FRAME: keep the
                                // staged byte for the tail entry
                                w_cut = 1'b1;
                            end else begin
                                w_push       = r_stage_valid;
                                w_push_entry = {2'b00, r_stage_data};
                                if (r_stage_valid && !w_room) w_overflow   = 1'b1;
                                else                          w_byte_store = 1'b1;
                            end
                        end
                    end else if (r_stage_valid) begin
                        w_push       = 1'b1;
                        w_push_entry = {w_end_err, 1'b1, r_stage_data};
                        if (w_room) w_frame_end = 1'b1;
                        else        w_overflow  = 1'b1;
                    end
                end
            end
            C_ST_TAIL: begin
                // Independent of rx_sym_en: flush as soon as space exists
                if (w_room) begin
                    w_push       = 1'b1;
                    w_tail_write = 1'b1;
                    w_push_entry = r_tail_stage ? {2'b11, r_stage_data} : {2'b11, 8'h00};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state       <= C_ST_IDLE;
            r_shift       <= '0;
            r_phase       <= '0;
            r_len         <= '0;
            r_stage_data  <= '0;
            r_stage_valid <= 1'b0;
            r_err_flag    <= 1'b0;
            r_tail_stage  <= 1'b0;
            r_overflow    <= 1'b0;
            r_frames_ok   <= '0;
            r_frames_err  <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (rx_sym_en && rx_dv) begin
                        r_shift <= {rx_d, {(8-SYM_W){1'b0}}};
                        r_state <= C_ST_PREAMBLE;
                    end
                end
                C_ST_PREAMBLE: begin
                    if (rx_sym_en) begin
                        if (!rx_dv) begin
                            r_state <= C_ST_IDLE;
                        end else begin
                            r_shift <= w_shift_next;
                            if (w_sfd_hit) begin
                                r_phase       <= '0;
                                r_len         <= '0;
                                r_stage_valid <= 1'b0;
                                r_err_flag    <= 1'b0;
                                r_tail_stage  <= 1'b0;
                                r_state       <= C_ST_DATA;
                            end
                        end
                    end
                end
                C_ST_DATA: begin
                    if (rx_sym_en) begin
                        if (rx_dv) begin
                            r_shift <= w_shift_next;
                            r_phase <= w_byte_done ? '0 : r_phase + 1'b1;
                            if (rx_err) r_err_flag <= 1'b1;
                            if (w_cut) begin
                                r_err_flag   <= 1'b1;
                                r_tail_stage <= 1'b1;
                                r_state      <= C_ST_DROP;
                            end else if (w_overflow) begin
                                r_overflow   <= 1'b1;
                                r_tail_stage <= 1'b0;
                                r_state      <= C_ST_DROP;
                            end else if (w_byte_store) begin
                                r_stage_data  <= w_shift_next;
                                r_stage_valid <= 1'b1;
                                r_len         <= r_len + 1'b1;
                            end
                        end else if (w_overflow) begin
                            r_overflow   <= 1'b1;
                            r_tail_stage <= 1'b0;
                            r_state      <= C_ST_DROP;
                        end else begin
                            // Normal end of frame, or zero-length frame
                            if (w_frame_end && !w_end_err) begin
                                if (~&r_frames_ok) r_frames_ok <= r_frames_ok + 1'b1;
                            end else begin
                                if (~&r_frames_err) r_frames_err <= r_frames_err + 1'b1;
                            end
                            r_stage_valid <= 1'b0;
                            r_state       <= C_ST_IDLE;
                        end
                    end
                end
                C_ST_DROP: begin
                    if (rx_sym_en && !rx_dv) r_state <= C_ST_TAIL;
                end
                C_ST_TAIL: begin
                    if (w_tail_write) begin
                        if (~&r_frames_err) r_frames_err <= r_frames_err + 1'b1;
                        r_stage_valid <= 1'b0;
                        r_tail_stage  <= 1'b0;
                        r_state       <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    mii_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (C_ENTRY_W)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Outputs are forced to zero while nothing is valid
    assign out_valid       = !w_fifo_empty;
    assign out_data        = w_fifo_empty ? 8'h00 : w_fifo_rdata[7:0];
    assign out_last        = !w_fifo_empty && w_fifo_rdata[8];
    assign out_err         = !w_fifo_empty && w_fifo_rdata[9];
    assign frames_ok       = r_frames_ok;
    assign frames_err      = r_frames_err;
    assign overflow_sticky = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mii_rx_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mii_rx_stream_bridge
// Description : Self-checking bench. DUT A is MII (4-bit, strobe every cycle,
//               16-entry FIFO); DUT B is RMII (2-bit, strobe every 2nd
//               cycle). A frame table drives DUT A; corner cases are written
//               out as explicit sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mii_rx_stream_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A signals
    logic       a_en, a_dv, a_er, a_ready;
    logic [3:0] a_d;
    logic [7:0] a_data;
    logic       a_valid, a_last, a_err, a_ovf;
    logic [15:0] a_ok, a_bad;

    // DUT B signals
    logic       b_en, b_dv, b_er, b_ready;
    logic [1:0] b_d;
    logic [7:0] b_data;
    logic       b_valid, b_last, b_err, b_ovf;
    logic [15:0] b_ok, b_bad;

    mii_rx_stream_bridge #(
        .SYM_W(4), .FIFO_DEPTH(16), .MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(16)
    ) u_dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n), .rx_sym_en(a_en), .rx_d(a_d),
        .rx_dv(a_dv), .rx_err(a_er), .out_data(a_data), .out_valid(a_valid),
        .out_ready(a_ready), .out_last(a_last), .out_err(a_err),
        .frames_ok(a_ok), .frames_err(a_bad), .overflow_sticky(a_ovf)
    );

    mii_rx_stream_bridge #(
        .SYM_W(2), .FIFO_DEPTH(16), .MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(16)
    ) u_dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .rx_sym_en(b_en), .rx_d(b_d),
        .rx_dv(b_dv), .rx_err(b_er), .out_data(b_data), .out_valid(b_valid),
        .out_ready(b_ready), .out_last(b_last), .out_err(b_err),
        .frames_ok(b_ok), .frames_err(b_bad), .overflow_sticky(b_ovf)
    );

    int tests = 0;
    int fails = 0;

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] got_q[$];
    logic [7:0] frame_q[$];

    // Output monitors: record every accepted byte as {err, last, data}
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) qa.push_back({a_err, a_last, a_data});
        if (rst_n && b_valid && b_ready) qb.push_back({b_err, b_last, b_data});
    end

    typedef struct {
        int len;        // bytes in the frame image
        int err_at;     // byte index carrying rx_err, -1 for none
        bit fcs;        // append a correct FCS
        bit dribble;    // one extra nibble before dv drops
        int exp_len;    // bytes expected on the output
        bit exp_err;    // err on last, FCS checker absent
        bit exp_err_fcs;// err on last, FCS checker present
    } vec_t;

    vec_t vt[9];

    function automatic vec_t mk(int len, int err_at, bit fcs, bit dribble,
                                int exp_len, bit exp_err, bit exp_err_fcs);
        vec_t v;
        v.len = len; v.err_at = err_at; v.fcs = fcs; v.dribble = dribble;
        v.exp_len = exp_len; v.exp_err = exp_err; v.exp_err_fcs = exp_err_fcs;
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC-32: reflected, init all-ones
    function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_frame(input int len, input bit fcs);
        logic [31:0] c;
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(8'(i));
        if (fcs) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) c = ref_crc(c, frame_q[i]);
            c = ~c;
            for (int k = 0; k < 4; k++) frame_q[len-4+k] = c[8*k +: 8];
        end
    endtask

    // ---- DUT A stimulus (strobe every cycle) ----
    task automatic a_sym(input logic [3:0] d, input logic dv, input logic er);
        a_en = 1'b1; a_d = d; a_dv = dv; a_er = er;
        tick();
    endtask

    task automatic a_byte(input logic [7:0] b, input logic er);
        a_sym(b[3:0], 1'b1, er);
        a_sym(b[7:4], 1'b1, er);
    endtask

    task automatic a_preamble();
        repeat (7) a_byte(8'h55, 1'b0);
        a_byte(8'hD5, 1'b0);
    endtask

    task automatic a_idle(input int n);
        repeat (n) a_sym(4'h0, 1'b0, 1'b0);
    endtask

    task automatic a_send(input int err_at, input bit dribble);
        a_preamble();
        for (int i = 0; i < frame_q.size(); i++) a_byte(frame_q[i], i == err_at);
        if (dribble) a_sym(4'hA, 1'b1, 1'b0);
        a_idle(24);
    endtask

    task automatic a_drain(input int budget);
        int t;
        t = 0;
        while (a_valid && t < budget) begin tick(); t++; end
        check("a_drain_timeout", a_valid, 0);
    endtask

    // ---- DUT B stimulus (strobe every second cycle) ----
    task automatic b_sym(input logic [1:0] d, input logic dv);
        b_en = 1'b1; b_d = d; b_dv = dv;
        tick();
        // Off-strobe cycle carries junk that must be ignored
        b_en = 1'b0; b_d = ~d; b_dv = ~dv;
        tick();
    endtask

    task automatic b_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) b_sym(b[2*k +: 2], 1'b1);
    endtask

    task automatic b_send();
        repeat (7) b_byte(8'h55);
        b_byte(8'hD5);
        for (int i = 0; i < frame_q.size(); i++) b_byte(frame_q[i]);
        repeat (12) b_sym(2'b00, 1'b0);
    endtask

    task automatic b_drain(input int budget);
        int t;
        t = 0;
        while (b_valid && t < budget) begin tick(); t++; end
        check("b_drain_timeout", b_valid, 0);
    endtask

    // Compare got_q against frame_q prefix with a single last/err at the end
    task automatic check_frame(input string tag, input int exp_len, input bit exp_err);
        int bad_at;
        int n_last;
        logic [9:0] fin;
        bad_at = -1;
        n_last = 0;
        check({tag, "_len"}, got_q.size(), exp_len);
        for (int k = 0; k < got_q.size(); k++) begin
            if (bad_at < 0 && k < frame_q.size() && got_q[k][7:0] !== frame_q[k]) bad_at = k;
            if (got_q[k][8]) n_last++;
        end
        check({tag, "_first_bad_byte_idx"}, bad_at, -1);
        check({tag, "_last_count"}, n_last, 1);
        fin = (got_q.size() > 0) ? got_q[got_q.size()-1] : 10'h000;
        check({tag, "_last_on_final"}, fin[8], 1);
        check({tag, "_err"}, fin[9], exp_err);
    endtask

    int  ea_ok, ea_bad, eb_ok, eb_bad;
    bit  e;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_en = 0; a_d = 0; a_dv = 0; a_er = 0; a_ready = 1'b1;
        b_en = 0; b_d = 0; b_dv = 0; b_er = 0; b_ready = 1'b1;
        ea_ok = 0; ea_bad = 0; eb_ok = 0; eb_bad = 0;

        vt[0] = mk(  64, -1, 0, 0,   64, 0, 1);
        vt[1] = mk( 100, 10, 0, 0,  100, 1, 1);
        vt[2] = mk(1600, -1, 0, 0, 1518, 1, 1);
        vt[3] = mk(  40, -1, 1, 0,   40, 1, 1);
        vt[4] = mk(  64, -1, 1, 0,   64, 0, 0);
        vt[5] = mk(1518, -1, 1, 0, 1518, 0, 0);
        vt[6] = mk(  63, -1, 1, 0,   63, 1, 1);
        vt[7] = mk(  64, -1, 1, 1,   64, 1, 1);
        vt[8] = mk(1519, -1, 1, 0, 1518, 1, 1);

        repeat (3) tick();
        // Reset state
        check("rst_valid", a_valid, 0);
        check("rst_data",  a_data,  0);
        check("rst_last",  a_last,  0);
        check("rst_err",   a_err,   0);
        check("rst_ok",    a_ok,    0);
        check("rst_bad",   a_bad,   0);
        check("rst_ovf",   a_ovf,   0);
        rst_n = 1'b1;
        tick();

        // ---- Table-driven frames on DUT A ----
        for (int r = 0; r < 9; r++) begin
            build_frame(vt[r].len, vt[r].fcs);
            a_send(vt[r].err_at, vt[r].dribble);
            a_drain(100);
`ifdef MII_RX_FCS_CHECK_EN
            e = vt[r].exp_err_fcs;
`else
            e = vt[r].exp_err;
`endif
            if (e) ea_bad++; else ea_ok++;
            got_q = qa; qa.delete();
            check_frame($sformatf("row%0d", r), vt[r].exp_len, e);
            check($sformatf("row%0d_frames_ok", r),  a_ok,  ea_ok);
            check($sformatf("row%0d_frames_err", r), a_bad, ea_bad);
        end
        check("no_ovf_yet", a_ovf, 0);

        // ---- Preamble-only pulse: nothing written, nothing counted ----
        repeat (7) a_byte(8'h55, 1'b0);
        a_idle(24);
        check("pre_only_out", qa.size(), 0);
        check("pre_only_ok",  a_ok,  ea_ok);
        check("pre_only_bad", a_bad, ea_bad);

        // ---- Zero-length frame: counted bad, no output ----
        a_preamble();
        a_idle(24);
        ea_bad++;
        check("zero_len_out", qa.size(), 0);
        check("zero_len_bad", a_bad, ea_bad);

        // ---- Overflow: ready held low through a 64-byte frame ----
        a_ready = 1'b0;
        build_frame(64, 1'b0);
        a_send(-1, 1'b0);
        check("ovf_sticky", a_ovf, 1);
        check("ovf_valid_held", a_valid, 1);
        a_ready = 1'b1;
        a_drain(100);
        ea_bad++;
        got_q = qa; qa.delete();
        check("ovf_len", got_q.size(), 17);
        begin
            int bad_at;
            int n_last;
            bad_at = -1;
            n_last = 0;
            for (int k = 0; k < got_q.size(); k++) begin
                if (k < 16 && bad_at < 0 && got_q[k] !== {2'b00, frame_q[k]}) bad_at = k;
                if (got_q[k][8]) n_last++;
            end
            check("ovf_first_bad_idx", bad_at, -1);
            check("ovf_last_count", n_last, 1);
            check("ovf_tail_entry", (got_q.size() > 0) ? got_q[got_q.size()-1] : 10'h000, 10'h300);
        end
        check("ovf_bad", a_bad, ea_bad);
        check("ovf_ok",  a_ok,  ea_ok);

        // ---- DUT B: RMII, valid FCS, then one FCS bit flipped ----
        build_frame(64, 1'b1);
        b_send();
        b_drain(100);
        eb_ok++;
        got_q = qb; qb.delete();
        check_frame("rmii_good", 64, 1'b0);
        check("rmii_good_ok",  b_ok,  eb_ok);
        check("rmii_good_bad", b_bad, eb_bad);

        build_frame(64, 1'b1);
        frame_q[62] = frame_q[62] ^ 8'h04;
        b_send();
        b_drain(100);
`ifdef MII_RX_FCS_CHECK_EN
        e = 1'b1;
`else
        e = 1'b0;
`endif
        if (e) eb_bad++; else eb_ok++;
        got_q = qb; qb.delete();
        check_frame("rmii_badfcs", 64, e);
        check("rmii_badfcs_ok",  b_ok,  eb_ok);
        check("rmii_badfcs_bad", b_bad, eb_bad);
        check("rmii_ovf", b_ovf, 0);

        // ---- Reset mid-frame with buffered bytes ----
        a_ready = 1'b0;
        a_preamble();
        for (int i = 0; i < 10; i++) a_byte(8'(i), 1'b0);
        rst_n = 1'b0;
        a_sym(4'h0, 1'b0, 1'b0);
        a_sym(4'h0, 1'b0, 1'b0);
        check("midrst_valid", a_valid, 0);
        check("midrst_ovf",   a_ovf,   0);
        check("midrst_ok",    a_ok,    0);
        check("midrst_bad",   a_bad,   0);
        rst_n = 1'b1;
        a_ready = 1'b1;
        qa.delete();
        ea_ok = 0; ea_bad = 0;
        a_idle(4);
        build_frame(64, 1'b1);
        a_send(-1, 1'b0);
        a_drain(100);
        ea_ok++;
        got_q = qa; qa.delete();
        check_frame("post_rst", 64, 1'b0);
        check("post_rst_ok",  a_ok,  ea_ok);
        check("post_rst_bad", a_bad, ea_bad);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mii_rx_stream_bridge.md
Name: mii_rx_stream_bridge

Overview:
Parametrised successor to the fabric-side MII attach on the HPS EMAC1 interface. Receives symbols from an MII/RMII-style receive port (4-bit or 2-bit per sampling strobe) and strips preamble/SFD. Assembles bytes, applies frame-length and error checks, and buffers frames in an internal FIFO. Delivers frames as a ready/valid byte stream with in-band last/err tags, plus saturating frame statistics, to FPGA-side logic.

Parameters:
SYM_W, 4, receive symbol width in bits; legal values 4 (MII) or 2 (RMII); symbols are LSB-first within a byte
FIFO_DEPTH, 64, output FIFO entries; power of two, at least 4
MIN_FRAME, 64, minimum legal frame length in bytes, FCS included
MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included
CNT_W, 16, statistics counter width

Ports:
clk_clk  in  1  single block clock
reset_reset_n  in  1  synchronous active-low reset
rx_sym_en  in  1  symbol sampling strobe; rx_* inputs are valid only when high
rx_d  in  SYM_W  receive symbol
rx_dv  in  1  receive data valid
rx_err  in  1  PHY receive error
out_data  out  8  frame byte
out_valid  out  1  out_data, out_last and out_err are valid
out_ready  in  1  downstream accepts the byte
out_last  out  1  final byte of the frame
out_err  out  1  frame is bad; meaningful only with out_last
frames_ok  out  CNT_W  saturating count of good frames
frames_err  out  CNT_W  saturating count of bad or dropped frames
overflow_sticky  out  1  set when any frame is truncated by a full FIFO; cleared only by reset

Behaviour:
- Reset is synchronous on clk_clk while reset_reset_n=0. Values: FSM=IDLE, FIFO empty, out_valid=0, out_last=0, out_err=0, out_data=0, counters=0, overflow_sticky=0.
- Reset mid-frame discards the FIFO contents and the partial frame. No tail entry is written.
- The FSM advances only on cycles with rx_sym_en=1. rx_* inputs are ignored otherwise.
- FSM states: IDLE, PREAMBLE, DATA, DROP, TAIL.
- IDLE: rx_dv=1 -> PREAMBLE. The first symbol enters an 8-bit LSB-first shift register.
- PREAMBLE: shift each symbol in. When the register equals 0xD5 -> DATA, with the byte phase and length counter cleared. rx_dv=0 -> IDLE; nothing is written and nothing is counted.
- DATA: accumulate 8/SYM_W symbols per byte. Each completed byte is held in a one-byte stage. The previously staged byte is pushed with last=0.
  - rx_dv=1 with rx_err=1 sets the frame error flag.
  - On the byte that would make the length MAX_FRAME+1: set the error flag and go to DROP.
  - rx_dv=0: push the staged byte with last=1 and err=flag. The flag is OR'd with a partial-byte condition (byte phase != 0) and with length < MIN_FRAME. Increment frames_ok or frames_err, then go to IDLE.
  - rx_dv=0 with no byte staged (zero-length frame): write nothing, increment frames_err, go to IDLE.
- A push into a full FIFO is not written. The block sets overflow_sticky and a pending-tail flag and goes to DROP.
- DROP: ignore symbols until rx_dv=0, then go to TAIL.
- TAIL: write one entry {data=0x00, last=1, err=1} on the first cycle the FIFO is not full, regardless of rx_sym_en. Increment frames_err, then go to IDLE.
  - If the frame was cut by MAX_FRAME and the FIFO has room, the staged byte is pushed with last=1, err=1 instead of the 0x00 entry.
  - rx_dv asserting while in TAIL is ignored. That frame is lost and is not counted.
- FIFO: entries are {err, last, data[7:0]}. First-word fall-through. out_valid=!empty. Pop on out_valid && out_ready. Push and pop in the same cycle are allowed when full, with no net change.
- Latency: a byte becomes visible on out_* 1 clk_clk after the push that follows its completion, i.e. after the next byte or the end of frame.
- Counters saturate at 2^CNT_W-1 and never wrap.

Optional Feature:
MII_RX_FCS_CHECK_EN
- Defined: a CRC-32 (IEEE 802.3, reflected, init 0xFFFFFFFF) runs over every DATA byte including the FCS. At end of frame, a residue != 0xC704DD7B sets err on the last entry and counts the frame in frames_err.
- Undefined: no CRC logic is built and the FCS is passed through unchecked. All other error sources are unchanged.

Decomposition:
- Package mii_rx_pkg holds:
  - the FSM state enum
  - SFD constant 0xD5
  - CRC polynomial 0xEDB88320 and residue 0xC704DD7B
  - FIFO entry width 10
- One sub-module, mii_rx_fifo: synchronous FWFT FIFO parametrised by depth and width, with full/empty outputs.

Test Plan:
- SYM_W=4, rx_sym_en=1 always, 7x0x55 + 0xD5 then 64 bytes 0x00..0x3F, dv drops: expect 64 bytes on out, last only on 0x3F, err=0, frames_ok=1.
- rx_err pulsed on byte 10 of a 100-byte frame: expect all 100 bytes, last err=1, frames_err=1.
- 1600-byte frame: expect exactly 1518 bytes, last/err on byte 1518, frames_err=1.
- out_ready=0, FIFO_DEPTH=16, 64-byte frame: expect overflow_sticky=1. After ready=1: 16 bytes then {0x00, last=1, err=1}.
- 40-byte runt and a dv pulse ending in PREAMBLE: runt delivered with err=1 and frames_err=1; preamble-only pulse produces no output and no count change.
- SYM_W=2, rx_sym_en every 2nd cycle, 64-byte frame with MII_RX_FCS_CHECK_EN and a valid FCS: err=0. Same frame with one FCS bit flipped: err=1.
